// File: rtl/riscv_decode_stage.sv
// riscv_decode_stage
//   RV32I instruction-decode stage. Holds the 32 x XLEN architectural register
//   file, decodes one instruction per cycle, builds the sign-extended immediate
//   and a packed 19-bit control bundle, and registers everything into the ID/EX
//   boundary (1-cycle latency, no stall). The WB stage writes the register file.
//
// Ports
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   instruction, pc_in    instruction word and its PC from fetch
//   write_en/_id/_data    register-file write port from WB (x0 writes ignored)
//   reg_rd_id             destination register (0 when the insn writes nothing)
//   read_data1/2          rs1 / rs2 values
//   immediate_data        sign-extended immediate
//   pc_out                pc_in delayed by one cycle
//   instruction_illegal   unsupported or malformed encoding (control forced to 0)
//   control_signals       {use_pc, funct3, is_jalr, is_jump, is_branch,
//                          mem_to_reg, reg_write, mem_write, mem_read,
//                          alu_src_imm, enc[2:0], alu_op[3:0]}
//
// Build option
//   WB_BYPASS_EN  when defined, a same-cycle WB write to rs1/rs2 is forwarded
//                 into read_data1/2; otherwise the pre-write value is captured.
module riscv_decode_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc_in,
    input  logic            write_en,
    input  logic [4:0]      write_id,
    input  logic [XLEN-1:0] write_data,
    output logic [4:0]      reg_rd_id,
    output logic [XLEN-1:0] read_data1,
    output logic [XLEN-1:0] read_data2,
    output logic [XLEN-1:0] immediate_data,
    output logic [XLEN-1:0] pc_out,
    output logic            instruction_illegal,
    output logic [18:0]     control_signals
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SRA   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [2:0] ENC_R = 3'd0;
    localparam logic [2:0] ENC_I = 3'd1;
    localparam logic [2:0] ENC_S = 3'd2;
    localparam logic [2:0] ENC_B = 3'd3;
    localparam logic [2:0] ENC_U = 3'd4;
    localparam logic [2:0] ENC_J = 3'd5;

    // ALU operation selected by funct3 alone (funct7 = 0 variants).
    function automatic logic [3:0] base_alu(input logic [2:0] f3);
        logic [3:0] op;
        case (f3)
            3'b000:  op = 4'd0;  // ADD
            3'b001:  op = 4'd7;  // SLL
            3'b010:  op = 4'd5;  // SLT
            3'b011:  op = 4'd6;  // SLTU
            3'b100:  op = 4'd4;  // XOR
            3'b101:  op = 4'd8;  // SRL
            3'b110:  op = 4'd3;  // OR
            3'b111:  op = 4'd2;  // AND
            default: op = 4'd0;
        endcase
        return op;
    endfunction

    logic [XLEN-1:0] regs_r [NREGS];

    logic [6:0] opcode_s, funct7_s;
    logic [2:0] funct3_s;
    logic [4:0] rs1_s, rs2_s, rd_s;

    logic [3:0] alu_op_s;
    logic [2:0] enc_s;
    logic alu_src_imm_s, mem_read_s, mem_write_s, reg_write_s, mem_to_reg_s;
    logic is_branch_s, is_jump_s, is_jalr_s, use_pc_s, illegal_s;
    logic [XLEN-1:0] imm_s, rdata1_s, rdata2_s;
    logic [18:0] ctrl_s;
    logic [4:0]  rd_final_s;

    assign opcode_s = instruction[6:0];
    assign rd_s     = instruction[11:7];
    assign funct3_s = instruction[14:12];
    assign rs1_s    = instruction[19:15];
    assign rs2_s    = instruction[24:20];
    assign funct7_s = instruction[31:25];

    // Main opcode decode: control fields and legality.
    always_comb begin
        alu_op_s      = ALU_ADD;
        enc_s         = ENC_R;
        alu_src_imm_s = 1'b0;
        mem_read_s    = 1'b0;
        mem_write_s   = 1'b0;
        reg_write_s   = 1'b0;
        mem_to_reg_s  = 1'b0;
        is_branch_s   = 1'b0;
        is_jump_s     = 1'b0;
        is_jalr_s     = 1'b0;
        use_pc_s      = 1'b0;
        illegal_s     = 1'b0;
        case (opcode_s)
            OPC_OP: begin
                enc_s       = ENC_R;
                reg_write_s = 1'b1;
                case (funct7_s)
                    7'b0000000: alu_op_s = base_alu(funct3_s);
                    7'b0100000: begin
                        if (funct3_s == 3'b000) begin
                            alu_op_s = ALU_SUB;
                        end else if (funct3_s == 3'b101) begin
                            alu_op_s = ALU_SRA;
                        end else begin
                            illegal_s = 1'b1;
                        end
                    end
                    default: illegal_s = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                enc_s         = ENC_I;
                alu_src_imm_s = 1'b1;
                reg_write_s   = 1'b1;
                alu_op_s      = base_alu(funct3_s);
                // Only the shift-immediates constrain the upper bits.
                if (funct3_s == 3'b001) begin
                    illegal_s = (funct7_s != 7'b0000000);
                end else if (funct3_s == 3'b101) begin
                    if (funct7_s == 7'b0100000) begin
                        alu_op_s = ALU_SRA;
                    end else begin
                        illegal_s = (funct7_s != 7'b0000000);
                    end
                end else begin
                    illegal_s = 1'b0;
                end
            end
            OPC_LOAD: begin
                enc_s         = ENC_I;
                alu_src_imm_s = 1'b1;
                mem_read_s    = 1'b1;
                reg_write_s   = 1'b1;
                mem_to_reg_s  = 1'b1;
                illegal_s     = (funct3_s == 3'b011) || (funct3_s == 3'b110) ||
                                (funct3_s == 3'b111);
            end
            OPC_STORE: begin
                enc_s         = ENC_S;
                alu_src_imm_s = 1'b1;
                mem_write_s   = 1'b1;
                illegal_s     = (funct3_s[2] == 1'b1) || (funct3_s == 3'b011);
            end
            OPC_BRANCH: begin
                enc_s       = ENC_B;
                alu_op_s    = ALU_SUB;
                is_branch_s = 1'b1;
                illegal_s   = (funct3_s == 3'b010) || (funct3_s == 3'b011);
            end
            OPC_JAL: begin
                enc_s       = ENC_J;
                is_jump_s   = 1'b1;
                reg_write_s = 1'b1;
                use_pc_s    = 1'b1;
            end
            OPC_JALR: begin
                enc_s         = ENC_I;
                is_jump_s     = 1'b1;
                is_jalr_s     = 1'b1;
                reg_write_s   = 1'b1;
                alu_src_imm_s = 1'b1;
                illegal_s     = (funct3_s != 3'b000);
            end
            OPC_LUI: begin
                enc_s         = ENC_U;
                alu_op_s      = ALU_PASSB;
                alu_src_imm_s = 1'b1;
                reg_write_s   = 1'b1;
            end
            OPC_AUIPC: begin
                enc_s         = ENC_U;
                alu_src_imm_s = 1'b1;
                use_pc_s      = 1'b1;
                reg_write_s   = 1'b1;
            end
            default: illegal_s = 1'b1;
        endcase
    end

    // Immediate generation; depends only on the opcode format, so it still
    // updates for an instruction flagged illegal by a funct field.
    always_comb begin
        imm_s = '0;
        case (opcode_s)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                imm_s = {{20{instruction[31]}}, instruction[31:20]};
            OPC_STORE:
                imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            OPC_BRANCH:
                imm_s = {{19{instruction[31]}}, instruction[31], instruction[7],
                         instruction[30:25], instruction[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm_s = {instruction[31:12], 12'h000};
            OPC_JAL:
                imm_s = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                         instruction[20], instruction[30:21], 1'b0};
            default: imm_s = '0;
        endcase
    end

    // Pack the bundle; an illegal instruction becomes a NOP with no destination.
    always_comb begin
        ctrl_s     = '0;
        rd_final_s = 5'd0;
        if (illegal_s) begin
            ctrl_s     = 19'd0;
            rd_final_s = 5'd0;
        end else begin
            ctrl_s = {use_pc_s, funct3_s, is_jalr_s, is_jump_s, is_branch_s,
                      mem_to_reg_s, reg_write_s, mem_write_s, mem_read_s,
                      alu_src_imm_s, enc_s, alu_op_s};
            rd_final_s = reg_write_s ? rd_s : 5'd0;
        end
    end

    // Register-file read ports (x0 hard-wired to zero).
    always_comb begin
        rdata1_s = (rs1_s == 5'd0) ? '0 : regs_r[rs1_s];
        rdata2_s = (rs2_s == 5'd0) ? '0 : regs_r[rs2_s];
`ifdef WB_BYPASS_EN
        if (write_en && (write_id != 5'd0) && (write_id == rs1_s)) begin
            rdata1_s = write_data;
        end else begin
            rdata1_s = rdata1_s;
        end
        if (write_en && (write_id != 5'd0) && (write_id == rs2_s)) begin
            rdata2_s = write_data;
        end else begin
            rdata2_s = rdata2_s;
        end
`endif
    end

    // Register-file write port from WB.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (write_en && (write_id != 5'd0)) begin
            regs_r[write_id] <= write_data;
        end
    end

    // ID/EX boundary registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_rd_id           <= 5'd0;
            read_data1          <= '0;
            read_data2          <= '0;
            immediate_data      <= '0;
            pc_out              <= '0;
            instruction_illegal <= 1'b0;
            control_signals     <= 19'd0;
        end else begin
            reg_rd_id           <= rd_final_s;
            read_data1          <= rdata1_s;
            read_data2          <= rdata2_s;
            immediate_data      <= imm_s;
            pc_out              <= pc_in;
            instruction_illegal <= illegal_s;
            control_signals     <= ctrl_s;
        end
    end

endmodule

// File: tb/tb_riscv_decode_stage.sv
module tb_riscv_decode_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] instruction, pc_in, write_data;
    logic        write_en;
    logic [4:0]  write_id;
    logic [4:0]  reg_rd_id;
    logic [31:0] read_data1, read_data2, immediate_data, pc_out;
    logic        instruction_illegal;
    logic [18:0] control_signals;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state and expectations for the last cycle
    logic [31:0] mregs [32];
    logic [18:0] exp_ctrl;
    logic [4:0]  exp_rd;
    logic [31:0] exp_imm, exp_r1, exp_r2, exp_pc;
    logic        exp_ill;

    localparam int BASE_ALU [8] = '{0, 7, 5, 6, 4, 8, 3, 2};
    localparam logic [6:0] OPS [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                        7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};

    riscv_decode_stage dut (
        .clk(clk), .reset_n(reset_n), .instruction(instruction), .pc_in(pc_in),
        .write_en(write_en), .write_id(write_id), .write_data(write_data),
        .reg_rd_id(reg_rd_id), .read_data1(read_data1), .read_data2(read_data2),
        .immediate_data(immediate_data), .pc_out(pc_out),
        .instruction_illegal(instruction_illegal), .control_signals(control_signals)
    );

    always #5 clk = ~clk;

    // Behavioural decoder written from the ISA rules.
    function automatic void ref_decode(input logic [31:0] ins, output logic [18:0] ctrl,
                                       output logic [4:0] rd, output logic [31:0] imm,
                                       output logic ill);
        int op, f3, f7, alu, enc;
        bit src, mr, mw, rw, m2r, br, jp, jr, upc;
        logic signed [12:0] bimm;
        logic signed [20:0] jimm;
        op = int'(ins[6:0]); f3 = int'(ins[14:12]); f7 = int'(ins[31:25]);
        alu = 0; enc = 0; src = 0; mr = 0; mw = 0; rw = 0; m2r = 0;
        br = 0; jp = 0; jr = 0; upc = 0; ill = 1'b0; imm = 32'd0;
        bimm = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        jimm = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        if (op == 'h33) begin
            rw = 1;
            if (f7 == 0) alu = BASE_ALU[f3];
            else if (f7 == 'h20 && f3 == 0) alu = 1;
            else if (f7 == 'h20 && f3 == 5) alu = 9;
            else ill = 1'b1;
        end else if (op == 'h13) begin
            enc = 1; src = 1; rw = 1; alu = BASE_ALU[f3];
            imm = 32'($signed(ins) >>> 20);
            if (f3 == 1 && f7 != 0) ill = 1'b1;
            if (f3 == 5 && f7 == 'h20) alu = 9;
            if (f3 == 5 && f7 != 0 && f7 != 'h20) ill = 1'b1;
        end else if (op == 'h03) begin
            enc = 1; src = 1; mr = 1; rw = 1; m2r = 1;
            imm = 32'($signed(ins) >>> 20);
            ill = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        end else if (op == 'h23) begin
            enc = 2; src = 1; mw = 1;
            imm = 32'(($signed(ins) >>> 25) <<< 5) | 32'(ins[11:7]);
            ill = (f3 > 2);
        end else if (op == 'h63) begin
            enc = 3; alu = 1; br = 1; imm = 32'(int'(bimm));
            ill = (f3 == 2 || f3 == 3);
        end else if (op == 'h6F) begin
            enc = 5; jp = 1; rw = 1; upc = 1; imm = 32'(int'(jimm));
        end else if (op == 'h67) begin
            enc = 1; jp = 1; jr = 1; rw = 1; src = 1;
            imm = 32'($signed(ins) >>> 20); ill = (f3 != 0);
        end else if (op == 'h37) begin
            enc = 4; alu = 10; src = 1; rw = 1; imm = ins & 32'hFFFFF000;
        end else if (op == 'h17) begin
            enc = 4; src = 1; upc = 1; rw = 1; imm = ins & 32'hFFFFF000;
        end else begin
            ill = 1'b1;
        end
        ctrl = {upc, 3'(f3), jr, jp, br, m2r, rw, mw, mr, src, 3'(enc), 4'(alu)};
        rd = rw ? ins[11:7] : 5'd0;
        if (ill) begin
            ctrl = 19'd0;
            rd = 5'd0;
        end
    endfunction

    // Drive one cycle of inputs, compute expectations, advance past the edge.
    task automatic cycle(input logic [31:0] ins, input logic [31:0] pc,
                         input logic we, input logic [4:0] wid, input logic [31:0] wd);
        instruction = ins; pc_in = pc; write_en = we; write_id = wid; write_data = wd;
        ref_decode(ins, exp_ctrl, exp_rd, exp_imm, exp_ill);
        exp_r1 = mregs[ins[19:15]];
        exp_r2 = mregs[ins[24:20]];
`ifdef WB_BYPASS_EN
        if (we && wid != 5'd0 && wid == ins[19:15]) exp_r1 = wd;
        if (we && wid != 5'd0 && wid == ins[24:20]) exp_r2 = wd;
`endif
        exp_pc = pc;
        @(posedge clk);
        #1;
        if (we && wid != 5'd0) mregs[wid] = wd;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        instruction = 32'h00500093; pc_in = 32'h1234; write_en = 1'b1;
        write_id = 5'd3; write_data = 32'h55;
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        @(posedge clk); #1;
        n_cmp++;
        if ({reg_rd_id, read_data1, read_data2, immediate_data, pc_out,
             instruction_illegal, control_signals} !== 153'd0) begin
            n_err++; $display("FAIL reset_outputs: got pc=%h imm=%h ctrl=%h, want all 0",
                              pc_out, immediate_data, control_signals);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_addi();
        cycle(32'h00500093, 32'h100, 1'b0, 5'd0, 32'd0);
        n_cmp++;
        if (immediate_data !== 32'd5 || reg_rd_id !== 5'd1 || read_data1 !== 32'd0 ||
            pc_out !== 32'h100 || control_signals !== 19'h00490 || instruction_illegal !== 1'b0) begin
            n_err++; $display("FAIL addi: got imm=%h rd=%0d r1=%h pc=%h ctrl=%h ill=%b, want 5/1/0/100/00490/0",
                              immediate_data, reg_rd_id, read_data1, pc_out, control_signals, instruction_illegal);
        end
    endtask

    task automatic test_regfile();
        cycle(32'h00000013, 32'h104, 1'b1, 5'd2, 32'hDEADBEEF);
        cycle(32'h002101B3, 32'h108, 1'b0, 5'd0, 32'd0);
        n_cmp++;
        if (read_data1 !== 32'hDEADBEEF || read_data2 !== 32'hDEADBEEF ||
            reg_rd_id !== 5'd3 || control_signals[7] !== 1'b0) begin
            n_err++; $display("FAIL add_read: got r1=%h r2=%h rd=%0d src=%b, want deadbeef/deadbeef/3/0",
                              read_data1, read_data2, reg_rd_id, control_signals[7]);
        end
        cycle(32'h00000013, 32'h10C, 1'b1, 5'd2, 32'h11111111);
        cycle(32'h002101B3, 32'h110, 1'b1, 5'd2, 32'hDEADBEEF);
        n_cmp++;
`ifdef WB_BYPASS_EN
        if (read_data1 !== 32'hDEADBEEF || read_data2 !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL same_cycle_bypass: got %h %h, want deadbeef", read_data1, read_data2);
        end
`else
        if (read_data1 !== 32'h11111111 || read_data2 !== 32'h11111111) begin
            n_err++; $display("FAIL same_cycle_nobypass: got %h %h, want 11111111", read_data1, read_data2);
        end
`endif
        cycle(32'h002101B3, 32'h114, 1'b0, 5'd0, 32'd0);
        n_cmp++;
        if (read_data1 !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL after_write: got %h, want deadbeef", read_data1);
        end
    endtask

    task automatic test_branch_lui();
        cycle(32'hFE000EE3, 32'h200, 1'b0, 5'd0, 32'd0);
        n_cmp++;
        if (immediate_data !== 32'hFFFFFFFC || control_signals[12] !== 1'b1 ||
            reg_rd_id !== 5'd0 || control_signals[10] !== 1'b0 || control_signals[3:0] !== 4'd1) begin
            n_err++; $display("FAIL beq: got imm=%h ctrl=%h rd=%0d, want fffffffc br=1 rd=0 sub",
                              immediate_data, control_signals, reg_rd_id);
        end
        cycle(32'h123452B7, 32'h204, 1'b0, 5'd0, 32'd0);
        n_cmp++;
        if (immediate_data !== 32'h12345000 || control_signals[3:0] !== 4'd10 || reg_rd_id !== 5'd5) begin
            n_err++; $display("FAIL lui: got imm=%h alu=%0d rd=%0d, want 12345000/10/5",
                              immediate_data, control_signals[3:0], reg_rd_id);
        end
    endtask

    task automatic test_x0();
        cycle(32'h00000013, 32'h300, 1'b1, 5'd0, 32'h1234);
        cycle(32'h00100113, 32'h304, 1'b0, 5'd0, 32'd0);  // addi x2,x0,1
        n_cmp++;
        if (read_data1 !== 32'd0) begin
            n_err++; $display("FAIL x0_read: got %h, want 0", read_data1);
        end
    endtask

    task automatic test_illegal_and_async_reset();
        cycle(32'h00000013, 32'h3FC, 1'b1, 5'd5, 32'hA5A5A5A5);
        cycle(32'hFFFFFFFF, 32'h400, 1'b0, 5'd0, 32'd0);
        n_cmp++;
        if (instruction_illegal !== 1'b1 || control_signals !== 19'd0 ||
            reg_rd_id !== 5'd0 || pc_out !== 32'h400) begin
            n_err++; $display("FAIL illegal: got ill=%b ctrl=%h rd=%0d pc=%h, want 1/0/0/400",
                              instruction_illegal, control_signals, reg_rd_id, pc_out);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({reg_rd_id, read_data1, read_data2, immediate_data, pc_out,
             instruction_illegal, control_signals} !== 153'd0) begin
            n_err++; $display("FAIL async_reset: got ill=%b pc=%h imm=%h, want 0",
                              instruction_illegal, pc_out, immediate_data);
        end
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        cycle(32'h002281B3, 32'h500, 1'b0, 5'd0, 32'd0);  // add x3,x5,x2
        n_cmp++;
        if (read_data1 !== 32'd0 || read_data2 !== 32'd0 || pc_out !== 32'h500) begin
            n_err++; $display("FAIL regs_cleared: got r1=%h r2=%h pc=%h, want 0/0/500",
                              read_data1, read_data2, pc_out);
        end
    endtask

    task automatic test_random();
        logic [31:0] ins, pc, wd;
        logic [4:0]  wid;
        logic        we;
        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            ins[6:0] = OPS[$urandom_range(0, 9)];
            if (ins[6:0] == 7'h7F) ins[6:0] = 7'($urandom);
            case ($urandom_range(0, 3))
                0: ins[31:25] = 7'h00;
                1: ins[31:25] = 7'h20;
                default: ins[31:25] = ins[31:25];
            endcase
            pc = $urandom;
            we = 1'($urandom);
            wid = ($urandom_range(0, 3) == 0) ? ins[19:15] : 5'($urandom);
            wd = $urandom;
            cycle(ins, pc, we, wid, wd);
            n_cmp++;
            if (control_signals !== exp_ctrl || reg_rd_id !== exp_rd || immediate_data !== exp_imm ||
                instruction_illegal !== exp_ill || read_data1 !== exp_r1 || read_data2 !== exp_r2 ||
                pc_out !== exp_pc) begin
                n_err++;
                $display("FAIL random[%0d] ins=%h: got ctrl=%h rd=%0d imm=%h ill=%b r1=%h r2=%h pc=%h, want ctrl=%h rd=%0d imm=%h ill=%b r1=%h r2=%h pc=%h",
                         n, ins, control_signals, reg_rd_id, immediate_data, instruction_illegal,
                         read_data1, read_data2, pc_out, exp_ctrl, exp_rd, exp_imm, exp_ill,
                         exp_r1, exp_r2, exp_pc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_regfile();
        test_branch_lui();
        test_x0();
        test_illegal_and_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
